// File: rtl/inner_product_accumulator_if.sv
// Chunk issue, product and result handshake bundle for the inner-product accumulator.
// The master side drives chunks, products and result acceptance; the slave side is the accumulator.
interface inner_product_accumulator_if #(
    parameter int CHUNKS = 4,
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    localparam int IDX_W = $clog2(CHUNKS);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  chunk_idx;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_data, out_valid, chunk_idx
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_data, out_valid, chunk_idx
    );
endinterface

// File: rtl/inner_product_accumulator.sv
// Sums CHUNKS latency-aligned chunk products into one dot product per long vector.
// Latency: final chunk issue to out_valid is LAT+1 cycles; non-final chunks stream at 1 per cycle.
// Backpressure: a final chunk is held off while the result slot is full or another final is in flight.
module inner_product_accumulator #(
    parameter int CHUNKS = 4,
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LAT    = 2
) (
    input logic                        clk,
    input logic                        rst,
    inner_product_accumulator_if.slave bus
);
    localparam int IDX_W = $clog2(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef struct packed {
        logic issued;
        logic is_final;
    } tag_t;

    logic [IDX_W-1:0] issue_cnt;
    tag_t             dly [LAT];
    tag_t             tap;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] out_data_q;
    logic [ACC_W-1:0] sum;
    logic             out_valid_q;
    logic             at_last;
    logic             issue;
    logic             final_in_flight;

    assign at_last = (issue_cnt == LAST_IDX);

    always_comb begin
        final_in_flight = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            final_in_flight = final_in_flight | dly[i].is_final;
        end
    end

    // Registered terms only, so a landing final chunk always finds the result slot empty.
    assign bus.in_ready  = !(at_last && (out_valid_q || final_in_flight));
    assign issue         = bus.in_valid && bus.in_ready;
    assign tap           = dly[LAT-1];
    assign sum           = acc + ACC_W'(bus.prod);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.chunk_idx = issue_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt   <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            if (issue) begin
                issue_cnt <= at_last ? '0 : issue_cnt + 1'b1;
            end

            dly[0] <= '{issued: issue, is_final: issue && at_last};
            for (int i = 1; i < LAT; i++) begin
                dly[i] <= dly[i-1];
            end

            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (tap.issued) begin
                if (tap.is_final) begin
                    out_data_q  <= sum;
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end
endmodule

// File: doc/inner_product_accumulator.md
# inner_product_accumulator

Downstream companion to the 3-element pipelined inner-product stage. It tracks which product-stage issues were valid, realigns that valid with the stage's fixed latency, and sums CHUNKS consecutive 8-bit chunk products into one long-vector dot product. It presents the result on a valid/ready output port and throttles upstream issue so that no completed result is lost.

## Interface
- CHUNKS, 4: 3-element chunks per long vector; must be ≥ 2.
- PROD_W, 8: width of the product-stage output.
- ACC_W, 16: accumulator and result width.
- LAT, 2: product-stage latency in cycles, from inputs to `prod`.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a chunk is presented to the product stage this cycle.
- in_ready  output  1  this block will accept the chunk; an issue occurs only when `in_valid && in_ready`.
- prod  input  PROD_W  product-stage output, valid LAT cycles after the issue.
- out_data  output  ACC_W  dot-product result.
- out_valid  output  1  `out_data` holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- chunk_idx  output  $clog2(CHUNKS)  index of the next chunk to issue (debug).

## Operation
- Issue counter `issue_cnt` (0..CHUNKS-1):
  - Increments on each issue.
  - Wraps to 0 after CHUNKS-1.
  - Drives `chunk_idx`.
- Valid delay line: LAT-deep shift register carrying `{issued, is_final}`, where `is_final = (issue_cnt == CHUNKS-1)` at issue time. Tap LAT marks a valid `prod`.
- On an aligned valid:
  - Non-final chunk: `acc <= acc + prod` (zero-extended).
  - Final chunk: `out_data <= acc + prod`, `out_valid <= 1`, `acc <= 0`.
- `prod` is ignored on cycles whose aligned valid is 0, regardless of its value.
- Arithmetic is modulo 2^ACC_W; no saturation and no flag.
- Output handshake:
  - `out_valid` clears on `out_valid && out_ready`.
  - `out_data` is held stable while `out_valid` is high and not accepted.
- Flow control: `in_ready = !(issue_cnt == CHUNKS-1 && (out_valid || final_in_flight))`.
  - `final_in_flight` is the OR of the `is_final` bits in the delay line.
  - The term uses registered state only; there is no combinational path from `out_ready`.
  - Non-final chunks are never blocked.
  - A final chunk is blocked until the output slot is empty and no earlier final chunk is in flight. This guarantees a landing final chunk never meets `out_valid = 1`.
- Simultaneous events:
  - Output accept and final landing in the same cycle cannot occur, by construction.
  - Accept and non-final landing in the same cycle: both take effect.
- Reset (any time, including mid-vector):
  - `acc`, `issue_cnt`, delay line, `out_valid` and `out_data` go to 0.
  - In-flight products are discarded.
  - The first chunk after reset is chunk 0.

## Timing
- Reset values:
  - `out_valid` = 0
  - `out_data` = 0
  - `chunk_idx` = 0
  - `in_ready` = 1
- Issue in cycle t: `prod` is sampled in cycle t+LAT and the accumulator updates at the end of t+LAT.
- A final chunk issued in cycle t raises `out_valid` in cycle t+LAT+1. End-to-end latency is LAT+1 = 3 cycles.
- Back-to-back issue sustains 1 chunk per cycle while the output is drained every cycle. A full vector costs CHUNKS cycles.
- `in_ready` changes only after a clock edge.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `chunk_idx` = 0; nothing is accumulated.
- Streaming (CHUNKS = 4, `out_ready` = 1): issue in t..t+3 with `prod` = 10, 20, 30, 40 aligned at t+2..t+5 → `out_valid` is high only in t+6, `out_data` = 100.
- Gaps: `in_valid` pattern 1,0,0,1,1,0,1 with valid products 5, 7, 9, 11 and `prod` = 255 on invalid slots → single result 32.
- Backpressure:
  - With `out_ready` = 0, complete a vector summing to 100 → `out_valid` = 1.
  - Issue three more chunks (accepted); `in_ready` = 0 at `chunk_idx` = 3.
  - `out_data` stays 100.
  - Raise `out_ready` for 1 cycle → `in_ready` returns to 1 on the next cycle, the final chunk issues, and the next result appears LAT+1 cycles later.
- Width and wrap:
  - CHUNKS = 4 with all `prod` = 147 → 588.
  - ACC_W = 8, CHUNKS = 2, `prod` = 147, 147 → 38 (294 mod 256).
- Reset mid-vector: 2 chunks accepted, one still in flight, assert `rst` for 1 cycle, then 4 chunks with `prod` = 1 → `out_data` = 4, with no spurious earlier `out_valid`.
